bp_cfg_responder: RTL and testbench

Configuration-space responder that terminates BedRock memory-forward (mem_fwd) write/read commands aimed at one core's config window. It decodes each command, updates or reads the core's control registers (freeze, NPC, I$/D$ mode, CCE mode) and a local CCE microcode RAM, and returns exactly one memory-reverse (mem_rev) response per command. It sits at the core end of the config path and faces the config loader that drives the same mem_fwd/mem_rev interface. It exports register values and a microcode read port to the core and CCE.

---
 rtl/bp_cfg_responder.sv | 148 ++++++++++++++
 tb/tb_bp_cfg_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_responder.sv
// Config-space responder: terminates mem_fwd commands aimed at one core's config window,
// owns the core control registers and the CCE microcode RAM, and returns one mem_rev per command.
module bp_cfg_responder #(
    parameter int                       paddr_width_p  = 40,
    parameter int                       lce_id_width_p = 8,
    parameter int                       did_width_p    = 3,
    parameter int                       vaddr_width_p  = 39,
    parameter int                       ucode_els_p    = 256,
    parameter logic [paddr_width_p-1:0] dram_base_p    = 40'h8000_0000,
    localparam int                      ucode_aw_lp    = $clog2(ucode_els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic [paddr_width_p-1:0]  fwd_addr_i,
    input  logic                      fwd_wr_i,
    input  logic [2:0]                fwd_size_i,
    input  logic [lce_id_width_p-1:0] fwd_lce_id_i,
    input  logic [did_width_p-1:0]    fwd_did_i,
    input  logic [63:0]               fwd_data_i,
    input  logic                      fwd_v_i,
    output logic                      fwd_ready_and_o,

    output logic [paddr_width_p-1:0]  rev_addr_o,
    output logic                      rev_wr_o,
    output logic [2:0]                rev_size_o,
    output logic [lce_id_width_p-1:0] rev_lce_id_o,
    output logic [did_width_p-1:0]    rev_did_o,
    output logic [63:0]               rev_data_o,
    output logic                      rev_v_o,
    input  logic                      rev_ready_and_i,

    output logic                      freeze_o,
    output logic [vaddr_width_p-1:0]  npc_o,
    output logic                      icache_mode_o,
    output logic                      dcache_mode_o,
    output logic                      cce_mode_o,

    input  logic                      ucode_v_i,
    input  logic [ucode_aw_lp-1:0]    ucode_addr_i,
    output logic [63:0]               ucode_data_o
);

    typedef enum logic [1:0] {e_ready, e_uread, e_resp} state_e;
    state_e state;

    logic [19:0]            off, u_off;
    logic                   fwd_hs, ucode_hit, ucode_ok, ram_we, ram_re;
    logic [ucode_aw_lp-1:0] ucode_idx;
    logic [63:0]            reg_rdata, ram_q;
    logic [63:0]            ucode_mem [ucode_els_p];

    assign off       = fwd_addr_i[19:0];
    assign u_off     = off - 20'h08000;
    assign ucode_idx = u_off[3 +: ucode_aw_lp];
    assign ucode_hit = (off >= 20'h08000) && (off[2:0] == 3'b000)
                     && ({3'b000, u_off[19:3]} < 20'(ucode_els_p));
    // Microcode is only reachable from the config port while the core is frozen
    assign ucode_ok  = ucode_hit & freeze_o;
    assign fwd_hs    = fwd_v_i & fwd_ready_and_o;
    assign ram_we    = fwd_hs & fwd_wr_i & ucode_ok;
    assign ram_re    = fwd_hs & ~fwd_wr_i & ucode_ok;

    always_comb begin
        reg_rdata = '0;
        if      (off == 20'h00000) reg_rdata = 64'(freeze_o);
        else if (off == 20'h00008) reg_rdata = 64'(npc_o);
        else if (off == 20'h00010) reg_rdata = 64'(icache_mode_o);
        else if (off == 20'h00018) reg_rdata = 64'(dcache_mode_o);
        else if (off == 20'h00020) reg_rdata = 64'(cce_mode_o);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= e_ready;
            fwd_ready_and_o <= 1'b0;
            rev_v_o         <= 1'b0;
            rev_addr_o      <= '0;
            rev_wr_o        <= 1'b0;
            rev_size_o      <= '0;
            rev_lce_id_o    <= '0;
            rev_did_o       <= '0;
            rev_data_o      <= '0;
            freeze_o        <= 1'b1;
            npc_o           <= dram_base_p[vaddr_width_p-1:0];
            icache_mode_o   <= 1'b0;
            dcache_mode_o   <= 1'b0;
            cce_mode_o      <= 1'b0;
        end else begin
            case (state)
                e_ready: begin
                    if (fwd_hs) begin
                        fwd_ready_and_o <= 1'b0;
                        rev_addr_o      <= fwd_addr_i;
                        rev_wr_o        <= fwd_wr_i;
                        rev_size_o      <= fwd_size_i;
                        rev_lce_id_o    <= fwd_lce_id_i;
                        rev_did_o       <= fwd_did_i;
                        rev_data_o      <= fwd_wr_i ? 64'h0 : reg_rdata;
                        if (fwd_wr_i) begin
                            if (off == 20'h00000) freeze_o      <= fwd_data_i[0];
                            if (off == 20'h00008) npc_o         <= fwd_data_i[vaddr_width_p-1:0];
                            if (off == 20'h00010) icache_mode_o <= fwd_data_i[0];
                            if (off == 20'h00018) dcache_mode_o <= fwd_data_i[0];
                            if (off == 20'h00020) cce_mode_o    <= fwd_data_i[0];
                        end
                        if (ram_re) begin
                            state <= e_uread;
                        end else begin
                            state   <= e_resp;
                            rev_v_o <= 1'b1;
                        end
                    end else begin
                        fwd_ready_and_o <= 1'b1;
                    end
                end
                e_uread: begin
                    rev_data_o <= ram_q;
                    rev_v_o    <= 1'b1;
                    state      <= e_resp;
                end
                e_resp: begin
                    if (rev_ready_and_i) begin
                        rev_v_o         <= 1'b0;
                        fwd_ready_and_o <= 1'b1;
                        state           <= e_ready;
                    end
                end
                default: state <= e_ready;
            endcase
        end
    end

    // RAM contents are not reset; only the output holding registers are
    always_ff @(posedge clk_i) begin
        if (ram_we) ucode_mem[ucode_idx] <= fwd_data_i;
        if (ram_re) ram_q <= ucode_mem[ucode_idx];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)     ucode_data_o <= '0;
        else if (ucode_v_i) ucode_data_o <= ucode_mem[ucode_addr_i];
    end

    logic unused_ok;
    assign unused_ok = ^{fwd_addr_i[paddr_width_p-1:20], u_off[2:0]};

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Self-checking bench for bp_cfg_responder: directed vector table, hand-written
// back-pressure / reset sequences, then random commands against a map-level model.
module tb_bp_cfg_responder;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [39:0] fwd_addr_i;
    logic        fwd_wr_i;
    logic [2:0]  fwd_size_i;
    logic [7:0]  fwd_lce_id_i;
    logic [2:0]  fwd_did_i;
    logic [63:0] fwd_data_i;
    logic        fwd_v_i;
    logic        fwd_ready_and_o;
    logic [39:0] rev_addr_o;
    logic        rev_wr_o;
    logic [2:0]  rev_size_o;
    logic [7:0]  rev_lce_id_o;
    logic [2:0]  rev_did_o;
    logic [63:0] rev_data_o;
    logic        rev_v_o;
    logic        rev_ready_and_i;
    logic        freeze_o;
    logic [38:0] npc_o;
    logic        icache_mode_o, dcache_mode_o, cce_mode_o;
    logic        ucode_v_i;
    logic [7:0]  ucode_addr_i;
    logic [63:0] ucode_data_o;

    bp_cfg_responder dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .fwd_addr_i(fwd_addr_i), .fwd_wr_i(fwd_wr_i), .fwd_size_i(fwd_size_i),
        .fwd_lce_id_i(fwd_lce_id_i), .fwd_did_i(fwd_did_i), .fwd_data_i(fwd_data_i),
        .fwd_v_i(fwd_v_i), .fwd_ready_and_o(fwd_ready_and_o),
        .rev_addr_o(rev_addr_o), .rev_wr_o(rev_wr_o), .rev_size_o(rev_size_o),
        .rev_lce_id_o(rev_lce_id_o), .rev_did_o(rev_did_o), .rev_data_o(rev_data_o),
        .rev_v_o(rev_v_o), .rev_ready_and_i(rev_ready_and_i),
        .freeze_o(freeze_o), .npc_o(npc_o), .icache_mode_o(icache_mode_o),
        .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o),
        .ucode_v_i(ucode_v_i), .ucode_addr_i(ucode_addr_i), .ucode_data_o(ucode_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the register map as plain variables plus a sparse microcode store
    bit          m_freeze, m_ic, m_dc, m_cce;
    logic [38:0] m_npc;
    logic [63:0] m_uc [int];

    function automatic void model_reset();
        m_freeze = 1'b1;
        m_npc    = 39'h80000000;
        m_ic = 1'b0; m_dc = 1'b0; m_cce = 1'b0;
        m_uc.delete();
    endfunction

    function automatic void model(input logic [39:0] a, input logic w, input logic [63:0] d,
                                  output logic [63:0] ed, output int el, output bit kn);
        int unsigned off;
        int          k;
        off = 32'(a[19:0]);
        ed = '0; el = 1; kn = 1'b1;
        if (off == 0)          begin if (w) m_freeze = d[0]; else ed = 64'(m_freeze); end
        else if (off == 8)     begin if (w) m_npc = d[38:0]; else ed = 64'(m_npc); end
        else if (off == 'h10)  begin if (w) m_ic = d[0]; else ed = 64'(m_ic); end
        else if (off == 'h18)  begin if (w) m_dc = d[0]; else ed = 64'(m_dc); end
        else if (off == 'h20)  begin if (w) m_cce = d[0]; else ed = 64'(m_cce); end
        else if (off >= 'h8000 && off < 'h8000 + 8*256 && off % 8 == 0 && m_freeze) begin
            k = int'((off - 'h8000) / 8);
            if (w) m_uc[k] = d;
            else begin
                el = 2;
                if (m_uc.exists(k)) ed = m_uc[k];
                else kn = 1'b0;
            end
        end
    endfunction

    task automatic chk_regs();
        chk("freeze_o", 64'(freeze_o), 64'(m_freeze));
        chk("npc_o", 64'(npc_o), 64'(m_npc));
        chk("icache_mode_o", 64'(icache_mode_o), 64'(m_ic));
        chk("dcache_mode_o", 64'(dcache_mode_o), 64'(m_dc));
        chk("cce_mode_o", 64'(cce_mode_o), 64'(m_cce));
    endtask

    // One full command with rev_ready_and_i high; returns data and accept-to-rev_v latency
    task automatic send(input logic [39:0] a, input logic w, input logic [63:0] d,
                        output logic [63:0] rd, output int lat);
        logic [2:0] sz;
        logic [7:0] lid;
        logic [2:0] did;
        int         n;
        sz = 3'($urandom); lid = 8'($urandom); did = 3'($urandom);
        fwd_addr_i = a; fwd_wr_i = w; fwd_data_i = d; fwd_size_i = sz;
        fwd_lce_id_i = lid; fwd_did_i = did; fwd_v_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!fwd_ready_and_o && n < 20) begin @(negedge clk_i); n++; end
        chk("accept_wait", 64'(n), 64'(0));
        @(posedge clk_i); #1;
        fwd_v_i = 1'b0;
        lat = 1;
        while (!rev_v_o && lat < 20) begin @(posedge clk_i); #1; lat++; end
        chk("rev_v_seen", 64'(rev_v_o), 64'(1));
        chk("fwd_ready_during_resp", 64'(fwd_ready_and_o), 64'(0));
        chk("rev_addr", 64'(rev_addr_o), 64'(a));
        chk("rev_wr", 64'(rev_wr_o), 64'(w));
        chk("rev_size", 64'(rev_size_o), 64'(sz));
        chk("rev_lce_id", 64'(rev_lce_id_o), 64'(lid));
        chk("rev_did", 64'(rev_did_o), 64'(did));
        rd = rev_data_o;
        @(posedge clk_i); #1;
    endtask

    typedef struct {
        logic [39:0] addr;
        logic        wr;
        logic [63:0] data;
        logic [63:0] exp;
        int          lat;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [39:0] a, input logic w, input logic [63:0] d,
                                input logic [63:0] e, input int l);
        vec_t v;
        v.addr = a; v.wr = w; v.data = d; v.exp = e; v.lat = l;
        tbl.push_back(v);
    endfunction

    task automatic cce_read(input logic [7:0] k, input logic [63:0] e, input string nm);
        ucode_v_i = 1'b1; ucode_addr_i = k;
        @(posedge clk_i); #1;
        ucode_v_i = 1'b0;
        chk(nm, ucode_data_o, e);
        @(posedge clk_i); #1;
        chk({nm, "_held"}, ucode_data_o, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, ed;
        int          lat, el;
        bit          kn;
        logic [19:0] off;
        logic [39:0] a;
        logic        w;
        logic [63:0] d;

        reset_n_i = 1'b0; fwd_addr_i = '0; fwd_wr_i = 1'b0; fwd_size_i = '0;
        fwd_lce_id_i = '0; fwd_did_i = '0; fwd_data_i = '0; fwd_v_i = 1'b0;
        rev_ready_and_i = 1'b1; ucode_v_i = 1'b0; ucode_addr_i = '0;
        model_reset();

        @(posedge clk_i); #1;
        chk("rst_fwd_ready", 64'(fwd_ready_and_o), 64'(0));
        chk("rst_rev_v", 64'(rev_v_o), 64'(0));
        chk("rst_rev_data", rev_data_o, 64'h0);
        chk("rst_rev_addr", 64'(rev_addr_o), 64'h0);
        chk("rst_ucode_data", ucode_data_o, 64'h0);
        chk_regs();
        @(negedge clk_i); reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_fwd_ready", 64'(fwd_ready_and_o), 64'(1));
        chk("post_rst_rev_v", 64'(rev_v_o), 64'(0));

        // addr, wr, data, expected rdata, expected latency
        add(40'h00008, 1, 64'h1234,                64'h0,                   1);
        add(40'h00008, 0, 64'h0,                   64'h1234,                1);
        add(40'h00010, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1);
        add(40'h00010, 0, 64'h0,                   64'h1,                   1);
        add(40'h00018, 1, 64'h2,                   64'h0,                   1);
        add(40'h00018, 0, 64'h0,                   64'h0,                   1);
        add(40'h00020, 1, 64'h3,                   64'h0,                   1);
        add(40'h00020, 0, 64'h0,                   64'h1,                   1);
        add(40'h08018, 1, 64'hDEAD_BEEF_0000_0001, 64'h0,                   1);
        add(40'h08018, 0, 64'h0,                   64'hDEAD_BEEF_0000_0001, 2);
        add(40'h087F8, 1, 64'h55,                  64'h0,                   1);
        add(40'h087F8, 0, 64'h0,                   64'h55,                  2);
        add(40'h08800, 0, 64'h0,                   64'h0,                   1);
        add(40'h00100, 0, 64'h0,                   64'h0,                   1);
        add(40'h00100, 1, 64'h5,                   64'h0,                   1);
        add(40'h00004, 0, 64'h0,                   64'h0,                   1);
        add(40'h00008, 1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0,                   1);
        add(40'hF0_0000_0008, 0, 64'h0,            64'h7F_FFFF_FFF0,        1);
        add(40'h00000, 0, 64'h0,                   64'h1,                   1);
        add(40'h00000, 1, 64'h0,                   64'h0,                   1);
        add(40'h00000, 0, 64'h0,                   64'h0,                   1);
        add(40'h08018, 1, 64'h77,                  64'h0,                   1);
        add(40'h08018, 0, 64'h0,                   64'h0,                   1);

        foreach (tbl[i]) begin
            model(tbl[i].addr, tbl[i].wr, tbl[i].data, ed, el, kn);
            send(tbl[i].addr, tbl[i].wr, tbl[i].data, rd, lat);
            chk($sformatf("vec%0d_data", i), rd, tbl[i].exp);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
            chk_regs();
        end

        cce_read(8'd3, 64'hDEAD_BEEF_0000_0001, "cce_k3");
        cce_read(8'd255, 64'h55, "cce_k255");

        // Back-pressure on an icache_mode read with a second command queued behind it
        rev_ready_and_i = 1'b0;
        model(40'h10, 1'b0, 64'h0, ed, el, kn);
        fwd_addr_i = 40'h10; fwd_wr_i = 1'b0; fwd_size_i = 3'd3;
        fwd_lce_id_i = 8'd5; fwd_did_i = 3'd2; fwd_v_i = 1'b1;
        @(negedge clk_i);
        chk("bp_first_ready", 64'(fwd_ready_and_o), 64'(1));
        @(posedge clk_i); #1;
        fwd_addr_i = 40'h18; fwd_wr_i = 1'b1; fwd_data_i = 64'h1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rev_v", 64'(rev_v_o), 64'(1));
            chk("bp_rev_addr", 64'(rev_addr_o), 64'h10);
            chk("bp_rev_wr", 64'(rev_wr_o), 64'(0));
            chk("bp_rev_lce", 64'(rev_lce_id_o), 64'd5);
            chk("bp_rev_did", 64'(rev_did_o), 64'd2);
            chk("bp_rev_data", rev_data_o, ed);
            chk("bp_fwd_ready", 64'(fwd_ready_and_o), 64'(0));
            @(posedge clk_i); #1;
        end
        chk("bp_second_blocked", 64'(dcache_mode_o), 64'(m_dc));
        rev_ready_and_i = 1'b1;
        @(posedge clk_i); #1;
        chk("bp_rev_drop", 64'(rev_v_o), 64'(0));
        @(posedge clk_i); #1;
        fwd_v_i = 1'b0;
        model(40'h18, 1'b1, 64'h1, ed, el, kn);
        chk("bp2_rev_v", 64'(rev_v_o), 64'(1));
        chk("bp2_rev_addr", 64'(rev_addr_o), 64'h18);
        chk("bp2_rev_wr", 64'(rev_wr_o), 64'(1));
        chk("bp2_dcache", 64'(dcache_mode_o), 64'(1));
        @(posedge clk_i); #1;

        // Reset while a response is pending
        rev_ready_and_i = 1'b0;
        fwd_addr_i = 40'h8; fwd_wr_i = 1'b0; fwd_v_i = 1'b1;
        @(negedge clk_i); @(posedge clk_i); #1;
        fwd_v_i = 1'b0;
        chk("rst_mid_pre_rev_v", 64'(rev_v_o), 64'(1));
        #2 reset_n_i = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_rev_v", 64'(rev_v_o), 64'(0));
        chk("rst_mid_fwd_ready", 64'(fwd_ready_and_o), 64'(0));
        chk("rst_mid_rev_data", rev_data_o, 64'h0);
        chk("rst_mid_rev_addr", 64'(rev_addr_o), 64'h0);
        chk("rst_mid_ucode_data", ucode_data_o, 64'h0);
        chk_regs();
        @(negedge clk_i); reset_n_i = 1'b1; rev_ready_and_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_mid_post_ready", 64'(fwd_ready_and_o), 64'(1));
        chk("rst_mid_post_rev_v", 64'(rev_v_o), 64'(0));

        // Random commands against the model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       off = 20'h00000;
                1:       off = 20'h00008;
                2:       off = 20'h00010;
                3:       off = 20'h00018;
                4:       off = 20'h00020;
                5, 6:    off = 20'h08000 + 20'(8 * $urandom_range(0, 15));
                7:       off = 20'h08000 + 20'(8 * $urandom_range(0, 255));
                8:       off = 20'($urandom);
                default: case ($urandom_range(0, 3))
                             0: off = 20'h08800;
                             1: off = 20'h08001;
                             2: off = 20'h07FF8;
                             default: off = 20'h10000;
                         endcase
            endcase
            a = {20'($urandom), off};
            w = 1'($urandom);
            d = {$urandom, $urandom};
            if (off == 20'h0 && w) d[0] = ($urandom_range(0, 3) != 0);
            model(a, w, d, ed, el, kn);
            send(a, w, d, rd, lat);
            if (kn) chk($sformatf("rnd%0d_data", n), rd, ed);
            chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(el));
            chk_regs();
            if (!m_freeze && $urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, 15);
                if (m_uc.exists(k)) cce_read(8'(k), m_uc[k], "rnd_cce");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
